prog_loader: RTL and testbench

//  Byte-stream program loader: the write side of the processor's program memory.
//  - The processor core only reads program memory. This block receives a framed

---
 rtl/prog_loader_pkg.sv | 15 +
 rtl/prog_loader.sv | 103 ++++++++++
 tb/tb_prog_loader.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and default frame marker.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_RUN  = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses SYNC/LEN/data/CSUM frames, writes program memory, gates core reset.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int                ADDR_W    = 5,
  parameter int                DATA_W    = 8,
  parameter int                DEPTH     = 16,
  parameter logic [DATA_W-1:0] SYNC_BYTE = DATA_W'(SYNC_DEFAULT),
  parameter bit                BOOT_RUN  = 1'b0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_rstn,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [DATA_W-1:0] DEPTH_D  = DATA_W'(DEPTH);
  localparam state_t            RESET_ST = BOOT_RUN ? ST_RUN : ST_IDLE;

  state_t            state, state_n;
  logic [ADDR_W-1:0] cnt, len;
  logic [DATA_W-1:0] csum;
  logic              accept, is_sync, len_ok, last_data, csum_ok;

  assign accept    = in_valid & in_ready;
  assign is_sync   = (in_data == SYNC_BYTE);
  assign len_ok    = (in_data != '0) && (in_data <= DEPTH_D);
  assign last_data = (cnt == len - ADDR_W'(1));
  assign csum_ok   = (in_data == csum);

  // SYNC only restarts outside a frame; inside LEN/DATA/CSUM it is ordinary payload.
  always_comb begin
    state_n = state;
    if (accept) begin
      case (state)
        ST_IDLE, ST_RUN, ST_ERR: if (is_sync) state_n = ST_LEN;
        ST_LEN:  state_n = len_ok ? ST_DATA : ST_ERR;
        ST_DATA: if (last_data) state_n = ST_CSUM;
        ST_CSUM: state_n = csum_ok ? ST_RUN : ST_ERR;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= RESET_ST;
      cnt       <= '0;
      len       <= '0;
      csum      <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      core_rstn <= BOOT_RUN;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state     <= state_n;
      in_ready  <= 1'b1;
      mem_we    <= 1'b0;
      load_done <= 1'b0;
      if (accept) begin
        case (state)
          ST_IDLE, ST_RUN, ST_ERR: begin
            if (is_sync) begin
              core_rstn <= 1'b0;
              load_err  <= 1'b0;
            end
          end
          ST_LEN: begin
            cnt  <= '0;
            csum <= in_data;
            len  <= in_data[ADDR_W-1:0];
          end
          ST_DATA: begin
            mem_we    <= 1'b1;
            mem_addr  <= cnt;
            mem_wdata <= in_data;
            csum      <= csum ^ in_data;
            cnt       <= cnt + ADDR_W'(1);
          end
          ST_CSUM: begin
            if (csum_ok) begin
              core_rstn <= 1'b1;
              load_done <= 1'b1;
            end
          end
          default: ;
        endcase
        if (state_n == ST_ERR && state != ST_ERR) load_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table-driven frames plus hand-written reset and gap sequences.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, mem_we, core_rstn, load_done, load_err;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;

  int checks = 0;
  int failures = 0;

  logic [4:0] wr_addr[$];
  logic [7:0] wr_data[$];
  int         done_cnt = 0;

  prog_loader #(.ADDR_W(5), .DATA_W(8), .DEPTH(16), .SYNC_BYTE(8'hA5), .BOOT_RUN(1'b0)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_rstn(core_rstn), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rstn && mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
    if (rstn && load_done) done_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0;
  endtask

  task automatic send(input logic [7:0] b);
    int w;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [63:0] bytes;
    int          n;
    int          exp_wr;
    logic [31:0] exp_data;
    logic        exp_core;
    logic        exp_err;
    int          exp_done;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{64'hA503112233030000, 6, 3, 32'h11223300, 1'b1, 1'b0, 1};
    vecs[1] = '{64'hA500000000000000, 2, 0, 32'h00000000, 1'b0, 1'b1, 0};
    vecs[2] = '{64'h1122000000000000, 2, 0, 32'h00000000, 1'b0, 1'b1, 0};
    vecs[3] = '{64'hA511000000000000, 2, 0, 32'h00000000, 1'b0, 1'b1, 0};
    vecs[4] = '{64'hA502AABB00000000, 5, 2, 32'hAABB0000, 1'b0, 1'b1, 0};
    vecs[5] = '{64'hA5015A5B00000000, 4, 1, 32'h5A000000, 1'b1, 1'b0, 1};
    vecs[6] = '{64'hA502A5A502000000, 5, 2, 32'hA5A50000, 1'b1, 1'b0, 1};
    vecs[7] = '{64'h1122330000000000, 3, 0, 32'h00000000, 1'b1, 1'b0, 0};

    // reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_core_rstn", 32'(core_rstn), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_rise", 32'(in_ready), 32'd1);

    for (int v = 0; v < 8; v++) begin
      clear_log();
      for (int i = 0; i < vecs[v].n; i++) send(vecs[v].bytes[63 - 8*i -: 8]);
      repeat (2) @(negedge clk);
      check($sformatf("v%0d_wr_count", v), 32'(wr_addr.size()), 32'(vecs[v].exp_wr));
      for (int i = 0; i < vecs[v].exp_wr && i < wr_addr.size(); i++) begin
        check($sformatf("v%0d_wr%0d_addr", v, i), 32'(wr_addr[i]), 32'(i));
        check($sformatf("v%0d_wr%0d_data", v, i), 32'(wr_data[i]), 32'(vecs[v].exp_data[31 - 8*i -: 8]));
      end
      check($sformatf("v%0d_core_rstn", v), 32'(core_rstn), 32'(vecs[v].exp_core));
      check($sformatf("v%0d_load_err", v), 32'(load_err), 32'(vecs[v].exp_err));
      check($sformatf("v%0d_done_cnt", v), 32'(done_cnt), 32'(vecs[v].exp_done));
    end

    // reload from RUN, then reset mid-frame
    clear_log();
    check("run_core_before_sync", 32'(core_rstn), 32'd1);
    send(8'hA5);
    check("core_drop_after_sync", 32'(core_rstn), 32'd0);
    send(8'h04);
    send(8'h3C);
    check("wr_latency_we", 32'(mem_we), 32'd1);
    check("wr_latency_addr", 32'(mem_addr), 32'd0);
    check("wr_latency_data", 32'(mem_wdata), 32'h3C);
    send(8'h4D);
    @(negedge clk);
    check("wr2_addr", 32'(mem_addr), 32'd1);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_core_rstn", 32'(core_rstn), 32'd0);
    check("midrst_mem_addr", 32'(mem_addr), 32'd0);
    check("midrst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("midrst_load_err", 32'(load_err), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    clear_log();
    send(8'h77);
    send(8'h01);
    repeat (2) @(negedge clk);
    check("idle_ignores_bytes", 32'(wr_addr.size()), 32'd0);
    check("idle_core_rstn", 32'(core_rstn), 32'd0);

    // full-depth load with random valid gaps
    begin
      logic [7:0] d;
      logic [7:0] cs;
      logic [7:0] exp_d[16];
      clear_log();
      send(8'hA5);
      send(8'h10);
      cs = 8'h10;
      for (int i = 0; i < 16; i++) begin
        d = 8'($urandom_range(0, 255));
        exp_d[i] = d;
        cs = cs ^ d;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send(d);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(cs);
      repeat (2) @(negedge clk);
      check("full_wr_count", 32'(wr_addr.size()), 32'd16);
      for (int i = 0; i < 16 && i < wr_addr.size(); i++) begin
        check($sformatf("full_wr%0d_addr", i), 32'(wr_addr[i]), 32'(i));
        check($sformatf("full_wr%0d_data", i), 32'(wr_data[i]), 32'(exp_d[i]));
      end
      check("full_core_rstn", 32'(core_rstn), 32'd1);
      check("full_done_cnt", 32'(done_cnt), 32'd1);
      check("full_load_err", 32'(load_err), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
